// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and types for the programmable clock divider.
package clk_div_pkg;

  localparam int unsigned RATIO_WIDTH_DEFAULT = 8;

  // Highest ratio that the downstream clock mux bypasses to the reference clock.
  localparam int unsigned DIV_BYPASS_MAX = 1;

  typedef logic [RATIO_WIDTH_DEFAULT-1:0] div_ratio_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } div_state_e;

endpackage

// File: rtl/clk_div_if.sv
// clk_div_if: enable/ratio request and divided-clock status bundle of clk_div_core.
interface clk_div_if
  import clk_div_pkg::*;
#(
  parameter int unsigned RATIO_WIDTH = RATIO_WIDTH_DEFAULT
) ();

  logic                   i_clk_en;
  logic [RATIO_WIDTH-1:0] i_div_ratio;
  logic                   o_div_clk;
  logic                   o_period_done;
  logic                   o_active;

  // Requester side: drives enable and ratio, observes the divider.
  modport master (
    output i_clk_en,
    output i_div_ratio,
    input  o_div_clk,
    input  o_period_done,
    input  o_active
  );

  // Divider side.
  modport slave (
    input  i_clk_en,
    input  i_div_ratio,
    output o_div_clk,
    output o_period_done,
    output o_active
  );

endinterface

// File: rtl/clk_div_counter.sv
// clk_div_counter: period position counter with wrap detect and high-phase compare.
// Build option: CLK_DIV_ODD_EN enables the ceil(N/2) low phase for odd ratios.
module clk_div_counter
  import clk_div_pkg::*;
#(
  parameter int unsigned RATIO_WIDTH = RATIO_WIDTH_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic                   clr_i,
  input  logic [RATIO_WIDTH-1:0] ratio_i,
  output logic                   wrap_c_o,
  output logic                   high_c_o
);

  logic [RATIO_WIDTH-1:0] cnt_q;
  logic [RATIO_WIDTH-1:0] cnt_d;
  logic [RATIO_WIDTH-1:0] low_len_c;

  // Length of the low phase: ceil(N/2); ratios are always even without odd support.
  always_comb begin
`ifdef CLK_DIV_ODD_EN
    low_len_c = (ratio_i >> 1) + RATIO_WIDTH'(ratio_i[0]);
`else
    low_len_c = ratio_i >> 1;
`endif
  end

  assign wrap_c_o = (cnt_q == (ratio_i - RATIO_WIDTH'(1)));
  assign high_c_o = (cnt_q >= low_len_c);

  // Next position: held at zero while parked, wraps on the last cycle of a period.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = wrap_c_o ? '0 : (cnt_q + RATIO_WIDTH'(1));
    end
  end

  // Position register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clk_div_core.sv
// clk_div_core: programmable integer divider of i_ref_clk with period-aligned ratio updates.
// Build option: CLK_DIV_ODD_EN honours odd ratios; otherwise the ratio LSB is dropped on load.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int unsigned RATIO_WIDTH = RATIO_WIDTH_DEFAULT
) (
  input  logic      i_ref_clk,
  input  logic      i_rst,
  clk_div_if.slave  bus
);

  localparam logic [RATIO_WIDTH-1:0] BYPASS_MAX = RATIO_WIDTH'(DIV_BYPASS_MAX);

  div_state_e             state_q;
  div_state_e             state_d;
  logic [RATIO_WIDTH-1:0] ratio_q;
  logic [RATIO_WIDTH-1:0] ratio_d;
  logic [RATIO_WIDTH-1:0] load_ratio_c;
  logic                   div_clk_q;
  logic                   div_clk_d;
  logic                   period_done_q;
  logic                   period_done_d;
  logic                   active_q;
  logic                   active_d;
  logic                   cnt_en_c;
  logic                   cnt_clr_c;
  logic                   wrap_c;
  logic                   high_c;

  // Ratio as it will be latched; odd ratios round down to even when unsupported.
  always_comb begin
`ifdef CLK_DIV_ODD_EN
    load_ratio_c = bus.i_div_ratio;
`else
    load_ratio_c = bus.i_div_ratio & ~RATIO_WIDTH'(1);
`endif
  end

  assign cnt_en_c  = bus.i_clk_en && (state_q == RUN);
  assign cnt_clr_c = (state_q == IDLE);

  clk_div_counter #(
    .RATIO_WIDTH (RATIO_WIDTH)
  ) u_counter (
    .clk_i    (i_ref_clk),
    .rst_i    (i_rst),
    .en_i     (cnt_en_c),
    .clr_i    (cnt_clr_c),
    .ratio_i  (ratio_q),
    .wrap_c_o (wrap_c),
    .high_c_o (high_c)
  );

  // Next state and registered outputs; everything holds while the enable is low.
  always_comb begin
    state_d       = state_q;
    ratio_d       = ratio_q;
    div_clk_d     = div_clk_q;
    period_done_d = 1'b0;
    active_d      = active_q;
    if (bus.i_clk_en) begin
      case (state_q)
        IDLE: begin
          ratio_d   = load_ratio_c;
          div_clk_d = 1'b0;
          active_d  = 1'b0;
          if (load_ratio_c > BYPASS_MAX) begin
            state_d = RUN;
          end
        end
        RUN: begin
          div_clk_d     = high_c;
          period_done_d = wrap_c;
          active_d      = 1'b1;
          if (wrap_c) begin
            ratio_d = load_ratio_c;
            if (load_ratio_c <= BYPASS_MAX) begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, active ratio and output registers.
  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= IDLE;
      ratio_q       <= '0;
      div_clk_q     <= 1'b0;
      period_done_q <= 1'b0;
      active_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      ratio_q       <= ratio_d;
      div_clk_q     <= div_clk_d;
      period_done_q <= period_done_d;
      active_q      <= active_d;
    end
  end

  assign bus.o_div_clk     = div_clk_q;
  assign bus.o_period_done = period_done_q;
  assign bus.o_active      = active_q;

endmodule

// File: tb/tb_clk_div_core.sv
// tb_clk_div_core: scenario tasks with a cycle model feeding an expected/observed scoreboard.
module tb_clk_div_core;

  localparam int unsigned W = 8;

  logic clk;
  logic rst;

  clk_div_if #(.RATIO_WIDTH(W)) bus ();

  clk_div_core #(.RATIO_WIDTH(W)) dut (
    .i_ref_clk (clk),
    .i_rst     (rst),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // Scoreboard entries are {o_div_clk, o_period_done, o_active}.
  logic [2:0] exp_q[$];
  logic [2:0] obs_q[$];

  // Reference model state.
  int   m_ratio;
  int   m_k;
  bit   m_run;
  logic m_clk;
  logic m_done;
  logic m_act;

  function automatic int eff_ratio(input int r);
`ifdef CLK_DIV_ODD_EN
    return r;
`else
    return r & ~1;
`endif
  endfunction

  task automatic model_reset();
    m_ratio = 0; m_k = 0; m_run = 0;
    m_clk = 1'b0; m_done = 1'b0; m_act = 1'b0;
  endtask

  task automatic model_edge(input bit en, input int r);
    if (!en) begin
      m_done = 1'b0;
      return;
    end
    if (!m_run) begin
      m_ratio = eff_ratio(r);
      m_clk = 1'b0; m_done = 1'b0; m_act = 1'b0; m_k = 0;
      if (m_ratio >= 2) m_run = 1;
    end else begin
      m_clk  = (m_k >= (m_ratio + 1) / 2);
      m_done = (m_k == m_ratio - 1);
      m_act  = 1'b1;
      if (m_k == m_ratio - 1) begin
        m_k = 0;
        m_ratio = eff_ratio(r);
        if (m_ratio < 2) m_run = 0;
      end else begin
        m_k++;
      end
    end
  endtask

  function automatic logic [2:0] sample();
    return {bus.o_div_clk, bus.o_period_done, bus.o_active};
  endfunction

  // One reference edge: drive, clock, then record model prediction and DUT output.
  task automatic cyc(input bit en, input int r);
    bus.i_clk_en    = en;
    bus.i_div_ratio = W'(r);
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else     model_edge(en, r);
    exp_q.push_back({m_clk, m_done, m_act});
    obs_q.push_back(sample());
  endtask

  task automatic apply_reset(input int r);
    rst = 1'b1;
    model_reset();
    cyc(1'b1, r);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] pat;
    logic [2:0] e, o;
    int i;
    pat = 4'b1100;
    rst = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if (sample() !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_async: got %b expected 000", sample());
    end
    repeat (3) cyc(1'b1, 4);
    rst = 1'b0;
    cyc(1'b1, 4);
    n_tests++;
    if (bus.o_active !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_active_at_load: got %b expected 0", bus.o_active);
    end
    for (int c = 0; c < 8; c++) begin
      cyc(1'b1, 4);
      n_tests++;
      if (bus.o_div_clk !== pat[c % 4] || bus.o_active !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_pattern cyc %0d: got clk=%b act=%b expected clk=%b act=1",
                 c, bus.o_div_clk, bus.o_active, pat[c % 4]);
      end
    end
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_sb entry %0d: got clk,done,act=%b expected %b", i, o, e);
      end
      i++;
    end
  endtask

  task automatic test_odd_ratio();
    logic [2:0] clk_pat;
    logic [2:0] e, o;
    int p, i;
`ifdef CLK_DIV_ODD_EN
    p = 3; clk_pat = 3'b100;
`else
    p = 2; clk_pat = 3'b010;
`endif
    apply_reset(3);
    cyc(1'b1, 3);
    for (int c = 0; c < 9; c++) begin
      cyc(1'b1, 3);
      n_tests++;
      if (bus.o_div_clk !== clk_pat[c % p] || bus.o_period_done !== ((c % p) == p - 1)) begin
        n_fail++;
        $display("FAIL odd_pattern cyc %0d: got clk=%b done=%b expected clk=%b done=%b",
                 c, bus.o_div_clk, bus.o_period_done, clk_pat[c % p], ((c % p) == p - 1));
      end
    end
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL odd_sb entry %0d: got clk,done,act=%b expected %b", i, o, e);
      end
      i++;
    end
  endtask

  task automatic test_mid_change();
    logic [9:0] pat;
    logic [2:0] e, o;
    int i;
    pat = 10'b1010101110;
    apply_reset(6);
    cyc(1'b1, 6);
    cyc(1'b1, 6);
    cyc(1'b1, 6);
    for (int c = 0; c < 10; c++) begin
      cyc(1'b1, 2);
      n_tests++;
      if (bus.o_div_clk !== pat[c]) begin
        n_fail++;
        $display("FAIL mid_change_clk cyc %0d: got %b expected %b", c, bus.o_div_clk, pat[c]);
      end
    end
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL mid_change_sb entry %0d: got clk,done,act=%b expected %b", i, o, e);
      end
      i++;
    end
  endtask

  task automatic test_park();
    logic [2:0] e, o;
    int i, highs, p5;
`ifdef CLK_DIV_ODD_EN
    p5 = 5;
`else
    p5 = 4;
`endif
    apply_reset(4);
    cyc(1'b1, 4);
    cyc(1'b1, 4);
    cyc(1'b1, 4);
    cyc(1'b1, 1);
    cyc(1'b1, 1);
    n_tests++;
    if (bus.o_period_done !== 1'b1 || bus.o_div_clk !== 1'b1) begin
      n_fail++;
      $display("FAIL park_finish: got done=%b clk=%b expected done=1 clk=1",
               bus.o_period_done, bus.o_div_clk);
    end
    for (int c = 0; c < 3; c++) begin
      cyc(1'b1, 1);
      n_tests++;
      if (bus.o_div_clk !== 1'b0 || bus.o_active !== 1'b0) begin
        n_fail++;
        $display("FAIL park_idle cyc %0d: got clk=%b act=%b expected 0 0",
                 c, bus.o_div_clk, bus.o_active);
      end
    end
    cyc(1'b1, 5);
    highs = 0;
    for (int c = 0; c < 10; c++) begin
      cyc(1'b1, 5);
      if (c < p5 && bus.o_div_clk === 1'b1) highs++;
    end
    n_tests++;
    if (highs !== 2) begin
      n_fail++;
      $display("FAIL park_resume_high: got %0d high cycles expected 2", highs);
    end
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL park_sb entry %0d: got clk,done,act=%b expected %b", i, o, e);
      end
      i++;
    end
  endtask

  task automatic test_enable_freeze();
    logic [2:0] e, o;
    int i;
    apply_reset(8);
    cyc(1'b1, 8);
    cyc(1'b1, 8);
    cyc(1'b1, 8);
    for (int c = 0; c < 7; c++) begin
      cyc(1'b0, 8);
      n_tests++;
      if (bus.o_period_done !== 1'b0 || bus.o_div_clk !== 1'b0 || bus.o_active !== 1'b1) begin
        n_fail++;
        $display("FAIL freeze_hold cyc %0d: got clk,done,act=%b expected 001", c, sample());
      end
    end
    for (int c = 0; c < 14; c++) begin
      cyc(1'b1, 8);
      n_tests++;
      if (bus.o_period_done !== (c == 5 || c == 13)) begin
        n_fail++;
        $display("FAIL freeze_resume_done cyc %0d: got %b expected %b",
                 c, bus.o_period_done, (c == 5 || c == 13));
      end
    end
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL freeze_sb entry %0d: got clk,done,act=%b expected %b", i, o, e);
      end
      i++;
    end
  endtask

  task automatic test_boundary_reset();
    logic [2:0] e, o;
    int i, p, highs, lows;
`ifdef CLK_DIV_ODD_EN
    p = 255;
`else
    p = 254;
`endif
    apply_reset(255);
    cyc(1'b1, 255);
    highs = 0; lows = 0;
    for (int c = 0; c < p; c++) begin
      cyc(1'b1, 255);
      if (bus.o_div_clk === 1'b1) highs++;
      else                        lows++;
    end
    n_tests++;
    if (highs !== 127 || lows !== p - 127 || bus.o_period_done !== 1'b1) begin
      n_fail++;
      $display("FAIL max_ratio_period: got high=%0d low=%0d done=%b expected high=127 low=%0d done=1",
               highs, lows, bus.o_period_done, p - 127);
    end
    repeat (200) cyc(1'b1, 255);
    n_tests++;
    if (bus.o_div_clk !== 1'b1 || bus.o_active !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_level: got clk=%b act=%b expected 1 1", bus.o_div_clk, bus.o_active);
    end
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if (sample() !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_period_reset: got %b expected 000", sample());
    end
    cyc(1'b1, 2);
    cyc(1'b1, 2);
    rst = 1'b0;
    repeat (6) cyc(1'b1, 2);
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL boundary_sb entry %0d: got clk,done,act=%b expected %b", i, o, e);
      end
      i++;
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.i_clk_en    = 1'b0;
    bus.i_div_ratio = '0;
    model_reset();
    test_reset();
    test_odd_ratio();
    test_mid_change();
    test_park();
    test_enable_freeze();
    test_boundary_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
